mac4x4_accum: RTL



---
 rtl/mac4x4_accum_pkg.sv | 12 +
 rtl/mac4x4_accum_if.sv | 25 ++
 rtl/mac4x4_accum_mult.sv | 24 ++
 rtl/mac4x4_accum.sv | 84 ++++++++
 4 files changed

// File: rtl/mac4x4_accum_pkg.sv
// rtl/mac4x4_accum_pkg.sv - shared encodings and widths for the 4x4 multiply-accumulate stage
package mac4x4_accum_pkg;

  localparam int OPND_W = 4;
  localparam int PROD_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/mac4x4_accum_if.sv
// rtl/mac4x4_accum_if.sv - operand and result handshake bundle for mac4x4_accum
interface mac4x4_accum_if #(
  parameter int ACC_W = 12
);
  import mac4x4_accum_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] a;
  logic [OPND_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_sum
  );

endinterface

// File: rtl/mac4x4_accum_mult.sv
// rtl/mac4x4_accum_mult.sv - combinational 4x4 unsigned array multiplier
module mac4x4_accum_mult
  import mac4x4_accum_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] row [OPND_W];
  logic [PROD_W-1:0] sum;

  // One shifted partial-product row per multiplier bit, summed down the array
  always_comb begin
    sum = '0;
    for (int i = 0; i < OPND_W; i++) begin
      row[i] = b[i] ? (PROD_W'(a) << i) : '0;
      sum    = sum + row[i];
    end
  end

  assign p = sum;

endmodule

// File: rtl/mac4x4_accum.sv
// rtl/mac4x4_accum.sv - registered 4x4 multiply-accumulate over N_TERMS operand pairs
module mac4x4_accum
  import mac4x4_accum_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  mac4x4_accum_if.slave  bus
);

  localparam int               CNT_W  = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  sum_cnt;
  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] p_q;
  logic [PROD_W-1:0] prod;
  logic              p_v;
  logic              accept;
  logic              deliver;

  mac4x4_accum_mult u_mult (
    .a (bus.a),
    .b (bus.b),
    .p (prod)
  );

  assign bus.in_ready  = (state_q == ACCUM) && (acc_cnt < N_LAST);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc;

  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = (state_q == HOLD) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACCUM;
    end else if (state_q == ACCUM) begin
      if (sum_cnt == N_LAST) state_d = HOLD;
    end else begin
      if (bus.out_ready) state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // clr and a delivered result both restart the batch from a clean slate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_cnt <= '0;
      sum_cnt <= '0;
      p_q     <= '0;
      p_v     <= 1'b0;
    end else if (clr || deliver) begin
      acc     <= '0;
      acc_cnt <= '0;
      sum_cnt <= '0;
      p_q     <= '0;
      p_v     <= 1'b0;
    end else begin
      p_v <= accept;
      if (accept) begin
        p_q     <= prod;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (p_v) begin
        acc     <= acc + ACC_W'(p_q);
        sum_cnt <= sum_cnt + 1'b1;
      end
    end
  end

endmodule
